// File: rtl/kvt_clk_ctrl_pkg.sv
// Shared types and default sizing for the clock-enable divider controller.
package kvt_clk_ctrl_pkg;

  // Command opcodes carried on cfg_op.
  typedef enum logic [1:0] {
    START      = 2'd0,
    STOP       = 2'd1,
    SET_PERIOD = 2'd2,
    RSVD       = 2'd3
  } cfg_op_e;

  // Per-channel sequencing state.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } ch_state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DIV_W  = 8;

endpackage

// File: rtl/kvt_clk_div_ch.sv
// One divider channel: phase toggles every cur_div cycles, tick marks each
// rising phase. Period changes take effect only at a toggle, and a stop only
// ever lands the phase low, so consumers never see a runt pulse.
module kvt_clk_div_ch
  import kvt_clk_ctrl_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             set,
  input  logic [DIV_W-1:0] div,
  output logic             phase,
  output logic             tick,
  output logic             running,
  output logic             in_run
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  ch_state_e        state, state_nxt;
  logic             phase_nxt;
  logic             tick_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] cur_div, cur_div_nxt;
  logic [DIV_W-1:0] pend_div, pend_div_nxt;
  logic             wrap;
  logic [DIV_W-1:0] reload;

  // A period write landing on the toggle edge itself applies to the interval
  // that starts there; otherwise a pending write is consumed at the toggle.
  assign wrap   = (cnt == '0);
  assign reload = set ? div : (pend_valid ? pend_div : cur_div);

  // Next-state, phase, tick and counter decisions for this channel.
  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    tick_nxt       = 1'b0;
    pend_valid_nxt = pend_valid;
    cnt_nxt        = cnt;
    cur_div_nxt    = cur_div;
    pend_div_nxt   = pend_div;

    case (state)
      IDLE: begin
        pend_valid_nxt = 1'b0;
        if (start) begin
          state_nxt   = RUN;
          phase_nxt   = 1'b1;
          tick_nxt    = 1'b1;
          cur_div_nxt = div;
          cnt_nxt     = div - ONE;
        end
      end

      RUN: begin
        if (stop) begin
          if (phase && !wrap) begin
            // High phase must finish its interval before parking low.
            state_nxt = STOPPING;
            cnt_nxt   = cnt - ONE;
          end else begin
            // Low phase, or a falling edge now: park immediately. A rising
            // toggle that would coincide is suppressed along with its tick.
            state_nxt      = IDLE;
            phase_nxt      = 1'b0;
            pend_valid_nxt = 1'b0;
          end
        end else if (wrap) begin
          phase_nxt      = ~phase;
          tick_nxt       = ~phase;
          cnt_nxt        = reload - ONE;
          cur_div_nxt    = reload;
          pend_valid_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - ONE;
          if (set) begin
            pend_div_nxt   = div;
            pend_valid_nxt = 1'b1;
          end
        end
      end

      STOPPING: begin
        if (wrap) begin
          state_nxt      = IDLE;
          phase_nxt      = 1'b0;
          pend_valid_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end

      default: begin
        state_nxt      = IDLE;
        phase_nxt      = 1'b0;
        pend_valid_nxt = 1'b0;
      end
    endcase
  end

  // Control state: cleared by reset so outputs drop low at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= 1'b0;
      tick       <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      tick       <= tick_nxt;
      pend_valid <= pend_valid_nxt;
    end
  end

  // Counter and divisor storage: always reloaded by START before use.
  always_ff @(posedge clk) begin
    cnt      <= cnt_nxt;
    cur_div  <= cur_div_nxt;
    pend_div <= pend_div_nxt;
  end

  assign running = (state != IDLE);
  assign in_run  = (state == RUN);

endmodule

// File: rtl/kvt_clk_div_ctrl.sv
// Multi-channel clock-enable controller: decodes and validates config
// commands, flags rejects one cycle later, and fans accepted commands out as
// single-cycle strobes to NUM_CH independent divider channels.
module kvt_clk_div_ctrl
  import kvt_clk_ctrl_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_op,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ch_phase,
  output logic [NUM_CH-1:0] ch_tick,
  output logic [NUM_CH-1:0] ch_running
);

  cfg_op_e           op;
  logic              accept;
  logic              ch_ok;
  logic              div_zero;
  logic              tgt_idle;
  logic              tgt_run;
  logic              reject;
  logic [NUM_CH-1:0] ch_in_run;

  assign op       = cfg_op_e'(cfg_op);
  assign accept   = cfg_valid & cfg_ready;
  assign ch_ok    = ({1'b0, cfg_ch} < 5'(NUM_CH));
  assign div_zero = (cfg_div == '0);

  // Look up the addressed channel's state without an out-of-range index.
  always_comb begin
    tgt_idle = 1'b0;
    tgt_run  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == 4'(i)) begin
        tgt_idle = ~ch_running[i];
        tgt_run  = ch_in_run[i];
      end
    end
  end

  // Command legality against the target channel's current state.
  always_comb begin
    reject = 1'b0;
    case (op)
      START:      reject = !ch_ok || div_zero || !tgt_idle;
      STOP:       reject = !ch_ok;
      SET_PERIOD: reject = !ch_ok || div_zero || !tgt_run;
      default:    reject = 1'b1;
    endcase
  end

  // Ready comes up on the first clock out of reset; errors are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= accept & reject;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [3:0] IDX = 4'(i);

    logic sel;
    logic start;
    logic stop;
    logic set;

    assign sel   = accept & ~reject & (cfg_ch == IDX);
    assign start = sel & (op == START);
    assign stop  = sel & (op == STOP);
    assign set   = sel & (op == SET_PERIOD);

    kvt_clk_div_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .stop    (stop),
      .set     (set),
      .div     (cfg_div),
      .phase   (ch_phase[i]),
      .tick    (ch_tick[i]),
      .running (ch_running[i]),
      .in_run  (ch_in_run[i])
    );
  end

endmodule

// File: tb/tb_kvt_clk_div_ctrl.sv
// Directed bench for kvt_clk_div_ctrl with hand-derived expected sequences.
module tb_kvt_clk_div_ctrl;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_op;
  logic [3:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_err;
  logic [NUM_CH-1:0] ch_phase;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_running;

  int n_chk  = 0;
  int n_pass = 0;

  logic [11:0] ph_h;
  logic [11:0] tk_h;

  always #5 clk = ~clk;

  kvt_clk_div_ctrl #(
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_op     (cfg_op),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_err    (cfg_err),
    .ch_phase   (ch_phase),
    .ch_tick    (ch_tick),
    .ch_running (ch_running)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] ch, input logic [DIV_W-1:0] div);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_ch    = ch;
    cfg_div   = div;
    step();
  endtask

  task automatic rec(input int c);
    ph_h = {ph_h[10:0], ch_phase[c]};
    tk_h = {tk_h[10:0], ch_tick[c]};
  endtask

  task automatic err_case(input string tag, input logic [1:0] op, input logic [3:0] ch,
                          input logic [DIV_W-1:0] div, input logic [3:0] exp_run);
    issue(op, ch, div);
    check({tag, "_err"}, cfg_err, 1);
    check({tag, "_run"}, ch_running, exp_run);
    check({tag, "_phase"}, ch_phase, 0);
    step();
    check({tag, "_clr"}, cfg_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int t0, t1, t2, t3, tk2;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_op    = 2'd0;
    cfg_ch    = 4'd0;
    cfg_div   = '0;
    ph_h      = '0;
    tk_h      = '0;

    repeat (3) step();
    check("rst_ready", cfg_ready, 0);
    check("rst_phase", ch_phase, 0);
    check("rst_tick", ch_tick, 0);
    check("rst_running", ch_running, 0);
    check("rst_err", cfg_err, 0);
    rst_n = 1'b1;
    step();
    check("ready_up", cfg_ready, 1);

    // ch0 div=3: three high, three low, tick every six.
    issue(OP_START, 4'd0, 8'd3);
    rec(0);
    check("ch0_running", ch_running, 4'b0001);
    for (int k = 1; k < 12; k++) begin
      step();
      rec(0);
    end
    check("ch0_phase_seq", ph_h, 12'b111000111000);
    check("ch0_tick_seq", tk_h, 12'b100000100000);

    // Next edge is a 0->1 toggle: stopping there suppresses it.
    issue(OP_STOP, 4'd0, 8'd0);
    check("stop_rise_phase", ch_phase[0], 0);
    check("stop_rise_tick", ch_tick[0], 0);
    check("stop_rise_run", ch_running[0], 0);
    check("stop_rise_err", cfg_err, 0);
    step();
    check("stop_rise_hold", ch_phase[0], 0);

    err_case("start_div0", OP_START, 4'd0, 8'd0, 4'b0000);
    err_case("set_idle", OP_SET, 4'd1, 8'd5, 4'b0000);
    err_case("ch_range", OP_START, 4'd4, 8'd3, 4'b0000);
    err_case("op_rsvd", OP_RSVD, 4'd0, 8'd3, 4'b0000);
    issue(OP_STOP, 4'd2, 8'd0);
    check("stop_idle_err", cfg_err, 0);
    check("stop_idle_run", ch_running, 0);

    // ch1 div=4, rejected re-START, then SET_PERIOD 2 mid-interval.
    issue(OP_START, 4'd1, 8'd4);
    rec(1);
    issue(OP_START, 4'd1, 8'd2);
    rec(1);
    check("start_busy_err", cfg_err, 1);
    issue(OP_SET, 4'd1, 8'd2);
    rec(1);
    check("set_ok_err", cfg_err, 0);
    for (int k = 3; k < 12; k++) begin
      step();
      rec(1);
    end
    check("ch1_phase_seq", ph_h, 12'b111100110011);
    check("ch1_tick_seq", tk_h, 12'b100000100010);

    // ch2 div=3: two SETs (last wins), then a SET on a toggle edge.
    issue(OP_START, 4'd2, 8'd3);
    rec(2);
    issue(OP_SET, 4'd2, 8'd5);
    rec(2);
    issue(OP_SET, 4'd2, 8'd2);
    rec(2);
    for (int k = 3; k < 7; k++) begin
      step();
      rec(2);
    end
    issue(OP_SET, 4'd2, 8'd3);
    rec(2);
    for (int k = 8; k < 12; k++) begin
      step();
      rec(2);
    end
    check("ch2_phase_seq", ph_h, 12'b111001100011);
    check("ch2_tick_seq", tk_h, 12'b100001000010);

    // ch2 high with one cycle left: STOP waits for the scheduled fall.
    issue(OP_STOP, 4'd2, 8'd0);
    check("stopping_phase", ch_phase[2], 1);
    check("stopping_run", ch_running[2], 1);
    check("stopping_err", cfg_err, 0);
    step();
    check("stopped_phase", ch_phase[2], 0);
    check("stopped_run", ch_running[2], 0);
    check("stopped_tick", ch_tick[2], 0);
    tk2 = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      tk2 += int'(ch_tick[2]);
    end
    check("stopped_no_ticks", tk2, 0);

    // ch1 low phase: STOP is immediate.
    w = 0;
    while (ch_phase[1] !== 1'b0 && w < 10) begin
      step();
      w++;
    end
    check("wait_ch1_low", (w < 10), 1);
    issue(OP_STOP, 4'd1, 8'd0);
    check("stop_low_phase", ch_phase[1], 0);
    check("stop_low_tick", ch_tick[1], 0);
    check("stop_low_run", ch_running, 0);

    // ch3 div=2: STOP on the 1->0 edge goes IDLE at that edge.
    issue(OP_START, 4'd3, 8'd2);
    step();
    issue(OP_STOP, 4'd3, 8'd0);
    check("stop_fall_phase", ch_phase[3], 0);
    check("stop_fall_run", ch_running[3], 0);

    // Four channels, div 1,2,3,5: ticks over a 60-cycle window.
    issue(OP_START, 4'd0, 8'd1);
    issue(OP_START, 4'd1, 8'd2);
    issue(OP_START, 4'd2, 8'd3);
    issue(OP_START, 4'd3, 8'd5);
    check("all_running", ch_running, 4'hF);
    t0 = 0; t1 = 0; t2 = 0; t3 = 0;
    for (int s = 0; s < 60; s++) begin
      if (s > 0) step();
      t0 += int'(ch_tick[0]);
      t1 += int'(ch_tick[1]);
      t2 += int'(ch_tick[2]);
      t3 += int'(ch_tick[3]);
    end
    check("ticks_div1", t0, 30);
    check("ticks_div2", t1, 15);
    check("ticks_div3", t2, 10);
    check("ticks_div5", t3, 6);

    // Reset mid-run clears everything at the edge.
    rst_n = 1'b0;
    step();
    check("mid_rst_phase", ch_phase, 0);
    check("mid_rst_tick", ch_tick, 0);
    check("mid_rst_run", ch_running, 0);
    check("mid_rst_ready", cfg_ready, 0);
    check("mid_rst_err", cfg_err, 0);
    step();
    check("mid_rst_ready_hold", cfg_ready, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", cfg_ready, 1);
    check("post_rst_phase", ch_phase, 0);
    check("post_rst_run", ch_running, 0);
    step();
    check("post_rst_phase_hold", ch_phase, 0);
    check("post_rst_tick", ch_tick, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
